// File: rtl/step_irq_ctrl.sv
// Step-button interrupt controller: synchronises and debounces the step input, queues
// the direction switch per press, and hands events to the processor one at a time.
module step_irq_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter int DEPTH           = 4,
  parameter int PEND_W          = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  input  logic              switch,
  input  logic              enable,
  input  logic              interrupt_ack,
  input  logic              clr_ovf,
  output logic              interrupt,
  output logic              dir,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0]  DEB_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PEND_W-1:0] FULL_CNT = PEND_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ASSERT,
    S_WAIT_DROP
  } state_e;

  logic              step_meta_q, step_s_q;
  logic              sw_meta_q, sw_s_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              stable_q, stable_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_d;
  state_e            state_q, state_d;
  logic              mem_q [DEPTH];

  logic push, pop, full, push_ok;

  // Debounce: a new level must persist DEBOUNCE_CYCLES clocks; only a rising edge is a press.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    push     = 1'b0;
    if (step_s_q != stable_q) begin
      if (cnt_q == DEB_MAX) begin
        stable_d = step_s_q;
        push     = step_s_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((pend_q != '0) && enable && !interrupt_ack) state_d = S_ASSERT;
      end
      S_ASSERT: begin
        if (interrupt_ack) begin
          pop     = 1'b1;
          state_d = S_WAIT_DROP;
        end
      end
      S_WAIT_DROP: begin
        if (!interrupt_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A simultaneous pop frees the head slot, so a push into a full queue still lands.
  always_comb begin
    full     = (pend_q == FULL_CNT);
    push_ok  = push && (!full || pop);
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    pend_d   = pend_q;
    case ({push_ok, pop})
      2'b10:   pend_d = pend_q + 1'b1;
      2'b01:   pend_d = pend_q - 1'b1;
      default: pend_d = pend_q;
    endcase
    ovf_d = ovf_q;
    if (push && full && !pop) ovf_d = 1'b1;
    else if (clr_ovf)         ovf_d = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_meta_q <= 1'b0;
      step_s_q    <= 1'b0;
      sw_meta_q   <= 1'b0;
      sw_s_q      <= 1'b0;
      cnt_q       <= '0;
      stable_q    <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pend_q      <= '0;
      ovf_q       <= 1'b0;
      state_q     <= S_IDLE;
    end else begin
      step_meta_q <= step;
      step_s_q    <= step_meta_q;
      sw_meta_q   <= switch;
      sw_s_q      <= sw_meta_q;
      cnt_q       <= cnt_d;
      stable_q    <= stable_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pend_q      <= pend_d;
      ovf_q       <= ovf_d;
      state_q     <= state_d;
    end
  end

  // NOTE: queue storage is not reset; dir is masked to 0 while the queue is empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= sw_s_q;
  end

  assign interrupt = (state_q == S_ASSERT);
  assign dir       = (pend_q != '0) ? mem_q[rd_ptr_q] : 1'b0;
  assign pending   = pend_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_step_irq_ctrl.sv
// Self-checking bench for step_irq_ctrl: directed scenarios plus a randomized sequence
// of presses/acks/clears checked against a transaction-level queue model.
module tb_step_irq_ctrl;

  localparam int DEB   = 4;
  localparam int DEPTH = 4;
  localparam int PW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          step, switch, enable, interrupt_ack, clr_ovf;
  logic          interrupt, dir, overflow;
  logic [PW-1:0] pending;

  int n_checks = 0;
  int n_fail   = 0;

  bit exp_q[$];
  bit exp_ovf;

  step_irq_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (3),
    .DEPTH          (DEPTH),
    .PEND_W         (PW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .step         (step),
    .switch       (switch),
    .enable       (enable),
    .interrupt_ack(interrupt_ack),
    .clr_ovf      (clr_ovf),
    .interrupt    (interrupt),
    .dir          (dir),
    .pending      (pending),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    check({tag, ".pending"},  32'(pending),  32'(exp_q.size()));
    check({tag, ".overflow"}, 32'(overflow), 32'(exp_ovf));
    check({tag, ".dir"},      32'(dir),      (exp_q.size() > 0) ? 32'(exp_q[0]) : 32'd0);
    check({tag, ".interrupt"}, 32'(interrupt), 32'(exp_q.size() > 0 && enable));
  endtask

  // Clean press with ack low; the model accepts it unless the queue is full.
  task automatic press(input bit sw);
    switch = sw;
    cyc(3);
    step = 1'b1;
    cyc(8);
    step = 1'b0;
    cyc(8);
    if (exp_q.size() < DEPTH) exp_q.push_back(sw);
    else                      exp_ovf = 1'b1;
  endtask

  // Press whose accept edge coincides with the ack edge of the presented event.
  task automatic press_with_ack(input bit sw);
    switch = sw;
    cyc(3);
    step = 1'b1;
    cyc(5);
    interrupt_ack = 1'b1;
    cyc(1);
    void'(exp_q.pop_front());
    exp_q.push_back(sw);
    check("pushpop.pending",   32'(pending),   32'(exp_q.size()));
    check("pushpop.interrupt", 32'(interrupt), 32'd0);
    check("pushpop.overflow",  32'(overflow),  32'(exp_ovf));
    interrupt_ack = 1'b0;
    cyc(2);
    step = 1'b0;
    cyc(8);
  endtask

  task automatic ack_cycle(input string tag);
    check({tag, ".irq_before"}, 32'(interrupt), 32'd1);
    check({tag, ".dir"},        32'(dir),       32'(exp_q[0]));
    interrupt_ack = 1'b1;
    cyc(1);
    void'(exp_q.pop_front());
    check({tag, ".irq_after"},  32'(interrupt), 32'd0);
    check({tag, ".pend_after"}, 32'(pending),   32'(exp_q.size()));
    interrupt_ack = 1'b0;
    cyc(2);
  endtask

  initial begin
    bit seen;
    rst = 1'b0; step = 1'b0; switch = 1'b0; enable = 1'b1;
    interrupt_ack = 1'b0; clr_ovf = 1'b0; exp_ovf = 1'b0;
    cyc(3);
    check("reset.interrupt", 32'(interrupt), 32'd0);
    check("reset.pending",   32'(pending),   32'd0);
    check("reset.dir",       32'(dir),       32'd0);
    check("reset.overflow",  32'(overflow),  32'd0);
    rst = 1'b1;
    cyc(2);

    // 1: single press, exact latency
    switch = 1'b1;
    cyc(3);
    step = 1'b1;
    cyc(5);
    check("t1.pend_edge5", 32'(pending), 32'd0);
    cyc(1);
    check("t1.pend_edge6", 32'(pending),   32'd1);
    check("t1.irq_edge6",  32'(interrupt), 32'd0);
    cyc(1);
    check("t1.irq_edge7",  32'(interrupt), 32'd1);
    check("t1.dir",        32'(dir),       32'd1);
    cyc(13);
    step = 1'b0;
    exp_q.push_back(1'b1);
    cyc(8);
    ack_cycle("t1.ack");
    check_model("t1.end");

    // 2: bouncing input never produces a press
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i % 2 == 0) step = ~step;
      cyc(1);
      if (interrupt || pending != '0) seen = 1'b1;
    end
    step = 1'b0;
    cyc(10);
    check("t2.bounce_activity", 32'(seen), 32'd0);
    check_model("t2.end");

    // 3: overflow and ordering
    press(1'b0); press(1'b1); press(1'b0); press(1'b1); press(1'b1);
    check("t3.pending",  32'(pending),  32'd4);
    check("t3.overflow", 32'(overflow), 32'd1);
    for (int i = 0; i < 4; i++) ack_cycle($sformatf("t3.ack%0d", i));
    check("t3.drained",   32'(pending),  32'd0);
    check("t3.ovf_stays", 32'(overflow), 32'd1);
    clr_ovf = 1'b1;
    cyc(1);
    clr_ovf = 1'b0;
    exp_ovf = 1'b0;
    check("t3.ovf_clr", 32'(overflow), 32'd0);

    // 4: push and pop on the same edge, half-full then full
    press(1'b1); press(1'b0);
    press_with_ack(1'b1);
    check_model("t4.half");
    press(1'b0); press(1'b1);
    check("t4.full", 32'(pending), 32'd4);
    press_with_ack(1'b0);
    check_model("t4.full_end");
    for (int i = 0; i < 4; i++) ack_cycle($sformatf("t4.ack%0d", i));
    check_model("t4.drained");

    // 5: enable gates only the interrupt
    enable = 1'b0;
    press(1'b1);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      cyc(1);
      if (interrupt) seen = 1'b1;
    end
    check("t5.gated_irq", 32'(seen),    32'd0);
    check("t5.pending",   32'(pending), 32'd1);
    enable = 1'b1;
    cyc(1);
    check("t5.irq_enabled", 32'(interrupt), 32'd1);

    // 6: asynchronous reset mid-handshake
    interrupt_ack = 1'b1;
    rst = 1'b0;
    #1;
    exp_q.delete();
    exp_ovf = 1'b0;
    check("t6.async_irq",  32'(interrupt), 32'd0);
    check("t6.async_pend", 32'(pending),   32'd0);
    check("t6.async_dir",  32'(dir),       32'd0);
    cyc(3);
    rst = 1'b1;
    cyc(4);
    check("t6.post_irq",  32'(interrupt), 32'd0);
    check("t6.post_pend", 32'(pending),   32'd0);
    interrupt_ack = 1'b0;
    cyc(2);

    // Randomized operations against the queue model
    for (int k = 0; k < 30; k++) begin
      int op;
      op = int'($urandom_range(0, 4));
      case (op)
        0, 1: press(1'($urandom));
        2: if (exp_q.size() > 0) ack_cycle($sformatf("rnd%0d.ack", k));
        3: begin
          clr_ovf = 1'b1;
          cyc(1);
          clr_ovf = 1'b0;
          exp_ovf = 1'b0;
        end
        default: if (exp_q.size() > 0) press_with_ack(1'($urandom));
      endcase
      check_model($sformatf("rnd%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/step_irq_ctrl.md
Name: step_irq_ctrl

Overview:
Event/interrupt controller between the front-panel step button, the direction switch and the TramelBlaze counter program. It synchronises and debounces the raw step input and records the direction switch per press in a small queue. It presents one event at a time to the processor through an interrupt/acknowledge handshake, so no presses are lost while the firmware updates the count and the 7-segment display.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive clocks the synced step must hold a new level before it is accepted (>=2)
CNT_W, 20, width of the debounce counter; must hold DEBOUNCE_CYCLES-1
DEPTH, 4, event queue entries (power of two)
PEND_W, 3, width of the pending count; must hold DEPTH

Ports:
clk  input  1  system clock (100 MHz)
rst  input  1  asynchronous, active-low reset; 0 = reset asserted
step  input  1  raw, asynchronous, bouncing push button
switch  input  1  raw, asynchronous direction switch; 1 = up, 0 = down
enable  input  1  permits interrupt assertion
interrupt_ack  input  1  processor acknowledge (level)
clr_ovf  input  1  clears the overflow flag
interrupt  output  1  event pending, to TramelBlaze
dir  output  1  direction of the head event
pending  output  PEND_W  events queued, including the one being presented
overflow  output  1  sticky flag: a press was dropped because the queue was full

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0. Sync flops, debounced state, debounce counter, queue pointers and FSM clear; FSM goes to IDLE.
- Synchronisers: step and switch each pass through 2 flops. Only the second-stage values (step_s, switch_s) are used.
- Debounce: counter increments each cycle step_s != stable and clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the inputs still differ, stable <= step_s and the counter clears.
  - A 0->1 transition of stable is a press. A 1->0 transition generates nothing.
- Push: on the clock edge where stable rises, switch_s is written to the queue tail and pending increments.
  - Total latency: pending increments DEBOUNCE_CYCLES+2 edges after the first edge that samples step=1.
- Full: a push when pending==DEPTH is dropped, pending is unchanged and overflow <= 1.
- overflow clears on clr_ovf=1. If a drop and clr_ovf occur on the same edge, set wins.
- Handshake FSM:
  - IDLE: go to ASSERT when pending>0, enable=1 and interrupt_ack=0. interrupt <= 1 on that edge, so interrupt rises one edge after pending becomes nonzero.
  - ASSERT: interrupt=1, dir = queue head, held stable. On interrupt_ack=1: pop head, pending decrements, interrupt <= 0, go to WAIT_DROP.
  - WAIT_DROP: interrupt=0. Go to IDLE when interrupt_ack=0. Each event therefore needs a full ack high->low cycle.
- Push and pop on the same edge: both take effect and pending is unchanged. A push is never dropped in this case, even if pending==DEPTH before the edge.
- enable=0 blocks only the IDLE->ASSERT transition. An asserted interrupt stays asserted until acked. Presses still queue.
- interrupt_ack while in IDLE is ignored.
- dir: equals the head entry in all states; 0 when pending==0.
- Queue pointers wrap modulo DEPTH. pending never exceeds DEPTH and never underflows.
- Reset mid-handshake: everything clears immediately. After release, an interrupt_ack held high causes no action.

Test Plan (DEBOUNCE_CYCLES=4, DEPTH=4, PEND_W=3):
1. Single press, switch=1, step high 20 cycles:
   - pending=1 at edge 6 after first sampled high; interrupt=1 at edge 7; dir=1.
   - ack high 1 cycle then low -> interrupt=0 and pending=0 on the next edge; FSM back to IDLE one edge after ack drops.
2. Bounce: step toggles every 2 cycles for 30 cycles, then held low -> pending stays 0, interrupt never asserts.
3. Overflow and ordering:
   - 5 clean presses, ack held low, switch=0,1,0,1,1 -> pending=4, overflow=1.
   - 4 ack cycles -> dir sequence 0,1,0,1, then pending=0; overflow stays 1.
   - clr_ovf pulse -> overflow=0.
4. Simultaneous push/pop: pending=2, a press completes on the same edge as ack -> pending stays 2 and interrupt drops. A DEPTH-full repeat with the same timing -> pending stays 4, overflow stays 0.
5. Gating: enable=0, one press -> pending=1, interrupt=0 for 50 cycles. enable=1 -> interrupt=1 on the next edge.
6. Reset mid-handshake: interrupt=1, ack=1, then rst=0 for 3 cycles -> all outputs 0 without waiting for a clock edge. Release rst with ack=1 -> interrupt stays 0 and pending=0.
